// File: rtl/seq_det_pkg.sv
// Shared definitions for the hit logger: default sizes and the record layout.
// A record is {first, gap}, with the gap field starting at bit 0.
package seq_det_pkg;
  localparam int GAP_W_DEF = 8;
  localparam int TOT_W_DEF = 16;
  localparam int DEPTH_DEF = 4;
  localparam int GAP_LSB   = 0;
  localparam int REC_W     = GAP_W_DEF + 1;
  localparam int FIRST_BIT = GAP_LSB + GAP_W_DEF;

  function automatic int rec_width(input int gap_w);
    return gap_w + 1;
  endfunction
endpackage

// File: rtl/seq_rec_fifo.sv
// First-word-fall-through record FIFO. An extra pointer MSB tells full from empty.
// The head word reads as zero while the FIFO is empty.
module seq_rec_fifo
  import seq_det_pkg::*;
#(
  parameter int WIDTH = REC_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // Writing while full is only legal when the head slot is freed in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/seq_hit_logger.sv
// Timestamps detector hits as saturating gaps, queues them for a valid/ready
// consumer, and keeps a running hit total plus a sticky drop flag.
module seq_hit_logger
  import seq_det_pkg::*;
#(
  parameter int GAP_W = GAP_W_DEF,
  parameter int TOT_W = TOT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             z,
  input  logic             en,
  input  logic             clear,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [GAP_W-1:0] rec_gap,
  output logic             rec_first,
  output logic [TOT_W-1:0] total,
  output logic             overflow
);
  localparam int RW = rec_width(GAP_W);
  localparam int FB = GAP_LSB + GAP_W;
  localparam logic [GAP_W-1:0] GAP_MAX = '1;

  logic [GAP_W-1:0] gap_cnt, gap_inc;
  logic             first_pend;
  logic             hit, pop, push, drop, full, empty;
  logic [RW-1:0]    wr_rec, head_rec;

  assign gap_inc   = (gap_cnt == GAP_MAX) ? GAP_MAX : gap_cnt + GAP_W'(1);
  assign hit       = z & en & ~clear;
  assign pop       = rec_valid & rec_ready & ~clear;
  assign push      = hit & (~full | pop);
  assign drop      = hit & full & ~pop;
  assign wr_rec    = {first_pend, gap_inc};
  assign rec_valid = ~empty;
  assign rec_gap   = head_rec[GAP_LSB +: GAP_W];
  assign rec_first = head_rec[FB];

  seq_rec_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (clear),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_rec),
    .rd_data (head_rec),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_cnt    <= '0;
      first_pend <= 1'b1;
      total      <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      gap_cnt    <= '0;
      first_pend <= 1'b1;
      total      <= '0;
      overflow   <= 1'b0;
    end else begin
      // With en low the gap counter freezes so disabled time is not counted.
      if (en)   gap_cnt    <= hit ? '0 : gap_inc;
      if (hit)  first_pend <= 1'b0;
      if (hit)  total      <= total + TOT_W'(1);
      if (drop) overflow   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_seq_hit_logger.sv
// Self-checking bench for seq_hit_logger: a hand-derived vector table, directed
// corner sequences, and random traffic against a queue-based reference model.
module tb_seq_hit_logger;
  localparam int GAP_W = 8;
  localparam int TOT_W = 16;
  localparam int DEPTH = 4;
  localparam int GMAX  = (1 << GAP_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             z = 1'b0, en = 1'b0, clear = 1'b0, rec_ready = 1'b0;
  logic             rec_valid, rec_first, overflow;
  logic [GAP_W-1:0] rec_gap;
  logic [TOT_W-1:0] total;

  int checks = 0;
  int errors = 0;

  seq_hit_logger #(.GAP_W(GAP_W), .TOT_W(TOT_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .z         (z),
    .en        (en),
    .clear     (clear),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_gap   (rec_gap),
    .rec_first (rec_first),
    .total     (total),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: queue of records, plain integer cycle count since last hit.
  typedef struct { int gap; bit first; } mrec_t;
  mrec_t m_q[$];
  int    m_since;
  bit    m_first_pend;
  int    m_total;
  bit    m_ovf;

  task automatic model_init();
    m_q.delete();
    m_since = 0;
    m_first_pend = 1'b1;
    m_total = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input bit mz, input bit men, input bit mclr, input bit mrdy);
    mrec_t r;
    if (mclr) begin
      model_init();
    end else begin
      if (m_q.size() > 0 && mrdy) void'(m_q.pop_front());
      if (mz && men) begin
        r.gap   = (m_since + 1 > GMAX) ? GMAX : m_since + 1;
        r.first = m_first_pend;
        m_since = 0;
        m_first_pend = 1'b0;
        m_total = (m_total + 1) % (1 << TOT_W);
        if (m_q.size() < DEPTH) m_q.push_back(r);
        else m_ovf = 1'b1;
      end else if (men) begin
        m_since = m_since + 1;
      end
    end
  endtask

  task automatic compare(input string name, input bit ev, input int eg, input bit ef,
                         input int et, input bit eo);
    checks++;
    if (rec_valid !== ev || int'(rec_gap) != eg || rec_first !== ef ||
        int'(total) != et || overflow !== eo) begin
      errors++;
      $display("FAIL %s: got valid=%0b gap=%0d first=%0b total=%0d ovf=%0b, expected valid=%0b gap=%0d first=%0b total=%0d ovf=%0b",
               name, rec_valid, rec_gap, rec_first, total, overflow, ev, eg, ef, et, eo);
    end
  endtask

  task automatic compare_model(input string name);
    bit ev; int eg; bit ef;
    ev = (m_q.size() > 0);
    eg = ev ? m_q[0].gap : 0;
    ef = ev ? m_q[0].first : 1'b0;
    compare(name, ev, eg, ef, m_total, m_ovf);
  endtask

  // Inputs are applied 1 time unit after an edge; outputs are sampled 1 unit after the next.
  task automatic cyc(input bit cz, input bit cen, input bit cclr, input bit crdy, input string name);
    z = cz; en = cen; clear = cclr; rec_ready = crdy;
    @(posedge clk);
    model_edge(cz, cen, cclr, crdy);
    #1;
    compare_model(name);
  endtask

  task automatic do_reset();
    #3;
    reset = 1'b0;
    #1;
    model_init();
    compare("async_reset", 1'b0, 0, 1'b0, 0, 1'b0);
    z = 1'b0; en = 1'b0; clear = 1'b0; rec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    bit z, en, clr, rdy;
    bit ev; int eg; bit ef; int et; bit eo;
  } vec_t;
  vec_t vt[18];

  initial begin
    int drained;

    vt[0]  = '{0,1,0,0, 0,0,0,0,0};
    vt[1]  = '{1,1,0,0, 1,2,1,1,0};
    vt[2]  = '{0,1,0,0, 1,2,1,1,0};
    vt[3]  = '{1,1,0,0, 1,2,1,2,0};
    vt[4]  = '{1,1,0,1, 1,2,0,3,0};
    vt[5]  = '{0,1,0,1, 1,1,0,3,0};
    vt[6]  = '{0,1,0,1, 0,0,0,3,0};
    vt[7]  = '{1,0,0,1, 0,0,0,3,0};
    vt[8]  = '{0,0,0,1, 0,0,0,3,0};
    vt[9]  = '{1,1,0,0, 1,3,0,4,0};
    vt[10] = '{1,1,0,0, 1,3,0,5,0};
    vt[11] = '{1,1,0,0, 1,3,0,6,0};
    vt[12] = '{1,1,0,0, 1,3,0,7,0};
    vt[13] = '{1,1,0,0, 1,3,0,8,1};
    vt[14] = '{1,1,0,1, 1,1,0,9,1};
    vt[15] = '{0,1,1,1, 0,0,0,0,0};
    vt[16] = '{1,1,1,0, 0,0,0,0,0};
    vt[17] = '{1,1,0,0, 1,1,1,1,0};

    model_init();
    do_reset();

    for (int i = 0; i < 18; i++) begin
      cyc(vt[i].z, vt[i].en, vt[i].clr, vt[i].rdy, $sformatf("model_vec%0d", i));
      compare($sformatf("table_vec%0d", i), vt[i].ev, vt[i].eg, vt[i].ef, vt[i].et, vt[i].eo);
    end

    // Full FIFO, simultaneous hit and pop: nothing is dropped, occupancy stays at DEPTH.
    cyc(0,1,1,0, "full_pop_clear");
    for (int i = 0; i < DEPTH; i++) cyc(1,1,0,0, "full_pop_fill");
    cyc(1,1,0,1, "full_pop_hit");
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_ovf: got %0b expected 0", overflow);
    end
    drained = 0;
    for (int i = 0; i < 10 && rec_valid; i++) begin
      cyc(0,1,0,1, "full_pop_drain");
      drained++;
    end
    checks++;
    if (drained != DEPTH) begin
      errors++;
      $display("FAIL full_pop_occupancy: got %0d expected %0d", drained, DEPTH);
    end

    // Long idle saturates the gap.
    cyc(0,1,1,0, "sat_clear");
    for (int i = 0; i < 300; i++) cyc(0,1,0,0, "sat_idle");
    cyc(1,1,0,0, "sat_hit");
    checks++;
    if (int'(rec_gap) != GMAX || rec_first !== 1'b1) begin
      errors++;
      $display("FAIL sat_gap: got gap=%0d first=%0b expected gap=%0d first=1", rec_gap, rec_first, GMAX);
    end

    // Disabled cycles are excluded from the gap, and z is ignored while disabled.
    cyc(0,1,1,0, "en_clear");
    cyc(1,1,0,1, "en_hit1");
    for (int i = 0; i < 3; i++)  cyc(0,1,0,1, "en_idle");
    for (int i = 0; i < 10; i++) cyc(1,0,0,1, "en_off");
    cyc(1,1,0,0, "en_hit2");
    checks++;
    if (int'(rec_gap) != 4 || rec_first !== 1'b0 || int'(total) != 2) begin
      errors++;
      $display("FAIL en_gap: got gap=%0d first=%0b total=%0d expected gap=4 first=0 total=2", rec_gap, rec_first, total);
    end

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 3; i++) cyc(1,1,0,0, "mid_fill");
    cyc(0,1,0,1, "mid_pop");
    do_reset();
    cyc(1,1,0,0, "post_reset_hit");
    checks++;
    if (rec_first !== 1'b1 || int'(total) != 1) begin
      errors++;
      $display("FAIL post_reset_first: got first=%0b total=%0d expected first=1 total=1", rec_first, total);
    end

    // Random traffic: dense hits with a slow consumer, then sparse hits.
    for (int i = 0; i < 2000; i++)
      cyc(1'($urandom_range(0,1)), $urandom_range(0,9) != 0, $urandom_range(0,99) == 0,
          $urandom_range(0,2) == 0, "rand_dense");
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0,199) == 0, $urandom_range(0,19) != 0, $urandom_range(0,499) == 0,
          $urandom_range(0,1) == 1, "rand_sparse");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
